// File: rtl/crossbar_output_arbiter.sv
// Per-output round-robin arbiter for an N x N crossbar. Each input names one
// destination output. Each output grants at most one requester per cycle. The
// winning set is registered as a per-input route/enable configuration.
// Optional feature: define CROSSBAR_ARB_LOCK_EN to hold an output on one input
// until that input's req_last beat (packet lock).
module crossbar_output_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned ROUTE_BITS = $clog2(N)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0]                       req_valid,
  input  logic [N-1:0][ROUTE_BITS-1:0]       req_route,
  input  logic [N-1:0]                       req_last,
  output logic [N-1:0]                       req_ready,
  output logic [N-1:0][ROUTE_BITS-1:0]       route,
  output logic [N-1:0]                       output_enable,
  output logic [15:0]                        conflict_cnt
);

  logic [N-1:0][ROUTE_BITS-1:0] ptr_q, ptr_d;
  logic [N-1:0][ROUTE_BITS-1:0] route_q, route_d;
  logic [N-1:0]                 oe_q, oe_d;
  logic [15:0]                  cnt_q, cnt_d;

  // elig[j][i]: input i may compete for output j this cycle
  logic [N-1:0][N-1:0]          elig;
  logic [N-1:0]                 win_valid;
  logic [N-1:0][ROUTE_BITS-1:0] win_idx;
  logic [N-1:0]                 ready_c;
  logic                         conflict;

`ifdef CROSSBAR_ARB_LOCK_EN
  logic [N-1:0]                 locked_q, locked_d;
  logic [N-1:0][ROUTE_BITS-1:0] owner_q, owner_d;
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  // Candidate matrix, masked to the lock owner when an output is locked.
  always_comb begin
    elig = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < N; i++) begin
        elig[j][i] = req_valid[i] && (req_route[i] == ROUTE_BITS'(j));
`ifdef CROSSBAR_ARB_LOCK_EN
        if (locked_q[j] && (owner_q[j] != ROUTE_BITS'(i))) begin
          elig[j][i] = 1'b0;
        end
`endif
      end
    end
  end

  // Round-robin pick per output. The scan runs from the farthest offset back
  // to ptr so that the nearest candidate is written last and wins.
  always_comb begin
    win_valid = '0;
    win_idx   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        if (elig[j][ptr_q[j] + ROUTE_BITS'(k)]) begin
          win_valid[j] = 1'b1;
          win_idx[j]   = ptr_q[j] + ROUTE_BITS'(k);
        end
      end
    end
  end

  // Grant back to inputs. An input asks for one output, so it wins at most once.
  always_comb begin
    ready_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ready_c[i] = req_valid[i] && win_valid[req_route[i]] &&
                   (win_idx[req_route[i]] == ROUTE_BITS'(i));
    end
    if (rst) begin
      ready_c = '0;
    end
    conflict = |(req_valid & ~ready_c);
  end

  // Next-state for pointers, lock state, config and conflict counter.
  always_comb begin
    ptr_d = ptr_q;
`ifdef CROSSBAR_ARB_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
`endif
    for (int unsigned j = 0; j < N; j++) begin
      if (win_valid[j]) begin
`ifdef CROSSBAR_ARB_LOCK_EN
        // Pointer moves only when the packet ends; mid-packet it holds.
        if (req_last[win_idx[j]]) begin
          ptr_d[j]    = win_idx[j] + ROUTE_BITS'(1);
          locked_d[j] = 1'b0;
        end else begin
          locked_d[j] = 1'b1;
          owner_d[j]  = win_idx[j];
        end
`else
        ptr_d[j] = win_idx[j] + ROUTE_BITS'(1);
`endif
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      route_d[i] = ready_c[i] ? req_route[i] : '0;
    end
    oe_d  = ready_c;
    cnt_d = (conflict && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      route_q <= '0;
      oe_q    <= '0;
      cnt_q   <= '0;
`ifdef CROSSBAR_ARB_LOCK_EN
      locked_q <= '0;
      owner_q  <= '0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      route_q <= route_d;
      oe_q    <= oe_d;
      cnt_q   <= cnt_d;
`ifdef CROSSBAR_ARB_LOCK_EN
      locked_q <= locked_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign req_ready     = ready_c;
  assign route         = route_q;
  assign output_enable = oe_q;
  assign conflict_cnt  = cnt_q;

endmodule
